// File: rtl/demux_pkg.sv
// Shared constants for the registered 1-to-4 demultiplexer.
// Select encodings and the slot count are shared by the top level and the bench.
package demux_pkg;

  localparam int NUM_SLOTS = 4;

  localparam logic [1:0] SLC_A = 2'b00;
  localparam logic [1:0] SLC_B = 2'b01;
  localparam logic [1:0] SLC_C = 2'b10;
  localparam logic [1:0] SLC_D = 2'b11;

endpackage

// File: rtl/demux_slot.sv
// One holding slot: captures din on wr and clears its valid flag on ack.
// A write in the same cycle as an ack wins, so the slot stays valid with new data.
module demux_slot #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         ack,
  input  logic [N-1:0] din,
  output logic [N-1:0] q,
  output logic         vld
);

  logic [N-1:0] q_q, q_d;
  logic         vld_q, vld_d;

  always_comb begin
    q_d   = q_q;
    vld_d = vld_q;
    if (wr) begin
      q_d   = din;
      vld_d = 1'b1;
    end else if (ack) begin
      // Consumed data is left in place; only the valid flag drops.
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      vld_q <= vld_d;
    end
  end

  assign q   = q_q;
  assign vld = vld_q;

endmodule

// File: rtl/demux1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-slot valid/ack back-pressure.
// A slot accepts new data only when empty or being consumed in the same cycle.
module demux1to4_reg
  import demux_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           slc,
  input  logic [N-1:0]         din,
  output logic [N-1:0]         w_a,
  output logic [N-1:0]         w_b,
  output logic [N-1:0]         w_c,
  output logic [N-1:0]         w_d,
  output logic [NUM_SLOTS-1:0] vld,
  input  logic [NUM_SLOTS-1:0] ack,
  output logic                 busy
);

  logic [NUM_SLOTS-1:0] sel_onehot;
  logic [NUM_SLOTS-1:0] wr;
  logic [N-1:0]         slot_q [NUM_SLOTS];
  logic                 acc;

  // Unknown select bits fall through to the default, so no slot is chosen.
  always_comb begin
    sel_onehot = '0;
    case (slc)
      SLC_A:   sel_onehot = 4'b0001;
      SLC_B:   sel_onehot = 4'b0010;
      SLC_C:   sel_onehot = 4'b0100;
      SLC_D:   sel_onehot = 4'b1000;
      default: sel_onehot = '0;
    endcase
  end

  assign in_ready = |(sel_onehot & (~vld | ack));
  assign acc      = in_valid & in_ready;
  assign wr       = sel_onehot & {NUM_SLOTS{acc}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      demux_slot #(.N(N)) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr[gi]),
        .ack   (ack[gi]),
        .din   (din),
        .q     (slot_q[gi]),
        .vld   (vld[gi])
      );
    end
  endgenerate

  assign w_a  = slot_q[0];
  assign w_b  = slot_q[1];
  assign w_c  = slot_q[2];
  assign w_d  = slot_q[3];
  assign busy = |vld;

endmodule

// File: tb/tb_demux1to4_reg.sv
// Directed bench for demux1to4_reg: reset, steering, back-pressure, consume,
// parallel events and illegal select, with hand-computed expectations.
module tb_demux1to4_reg;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  slc;
  logic [15:0] din;
  logic [15:0] w_a, w_b, w_c, w_d;
  logic [3:0]  vld;
  logic [3:0]  ack;
  logic        busy;

  int errors = 0;
  int checks = 0;

  demux1to4_reg #(.N(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .slc      (slc),
    .din      (din),
    .w_a      (w_a),
    .w_b      (w_b),
    .w_c      (w_c),
    .w_d      (w_d),
    .vld      (vld),
    .ack      (ack),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; slc = 2'b00; din = '0; ack = '0;
    tick();
    checks++;
    if (vld !== 4'b0000 || busy !== 1'b0 || w_a !== 16'h0 || w_d !== 16'h0) begin
      errors++;
      $display("FAIL reset_init: vld=%b busy=%b w_a=%h w_d=%h, need 0000/0/0000/0000", vld, busy, w_a, w_d);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    // Fill slots a and c so the mid-run reset has something to discard.
    in_valid = 1'b1; slc = 2'b00; din = 16'h1111;
    tick();
    slc = 2'b10; din = 16'h3333;
    tick();
    in_valid = 1'b0;
    checks++;
    if (vld !== 4'b0101) begin
      errors++;
      $display("FAIL reset_prefill: vld=%b, need 0101", vld);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (w_a !== 16'h0 || w_b !== 16'h0 || w_c !== 16'h0 || w_d !== 16'h0 || vld !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: w=%h/%h/%h/%h vld=%b busy=%b, need all zero", w_a, w_b, w_c, w_d, vld, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    slc = 2'b01;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, need 1", in_ready);
    end
    $display("test_reset done: vld=%b busy=%b", vld, busy);
  endtask

  task automatic test_steer();
    in_valid = 1'b1; slc = 2'b10; din = 16'hBEEF;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL steer_ready: in_ready=%b, need 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (w_c !== 16'hBEEF || vld !== 4'b0100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL steer_c: w_c=%h vld=%b busy=%b, need BEEF/0100/1", w_c, vld, busy);
    end
    checks++;
    if (w_a !== 16'h0 || w_b !== 16'h0 || w_d !== 16'h0) begin
      errors++;
      $display("FAIL steer_others: w_a=%h w_b=%h w_d=%h, need 0000", w_a, w_b, w_d);
    end
    ack = 4'b0100;
    tick();
    ack = 4'b0000;
    $display("test_steer done: w_c=%h vld=%b", w_c, vld);
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; slc = 2'b01; din = 16'h1234;
    tick();
    din = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready_low[%0d]: in_ready=%b, need 0", i, in_ready);
      end
      tick();
      checks++;
      if (w_b !== 16'h1234) begin
        errors++;
        $display("FAIL bp_hold[%0d]: w_b=%h, need 1234", i, w_b);
      end
    end
    ack = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_ack: in_ready=%b, need 1", in_ready);
    end
    tick();
    ack = 4'b0000; in_valid = 1'b0;
    checks++;
    if (w_b !== 16'h5678 || vld[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_refill: w_b=%h vld[1]=%b, need 5678/1", w_b, vld[1]);
    end
    $display("test_backpressure done: w_b=%h vld=%b", w_b, vld);
  endtask

  task automatic test_consume();
    in_valid = 1'b1; slc = 2'b11; din = 16'h00FF;
    tick();
    in_valid = 1'b0; ack = 4'b1000;
    tick();
    ack = 4'b0000;
    checks++;
    if (vld !== 4'b0010 || w_d !== 16'h00FF) begin
      errors++;
      $display("FAIL consume: vld=%b w_d=%h, need 0010/00FF", vld, w_d);
    end
    ack = 4'b1000;
    tick();
    ack = 4'b0000;
    checks++;
    if (vld !== 4'b0010 || w_d !== 16'h00FF || w_b !== 16'h5678) begin
      errors++;
      $display("FAIL consume_empty_ack: vld=%b w_d=%h w_b=%h, need 0010/00FF/5678", vld, w_d, w_b);
    end
    ack = 4'b0010;
    tick();
    ack = 4'b0000;
    $display("test_consume done: vld=%b w_d=%h", vld, w_d);
  endtask

  task automatic test_parallel();
    in_valid = 1'b1; slc = 2'b00; din = 16'h0011;
    tick();
    slc = 2'b01; din = 16'h0022;
    tick();
    checks++;
    if (vld !== 4'b0011) begin
      errors++;
      $display("FAIL par_setup: vld=%b, need 0011", vld);
    end
    ack = 4'b0011; slc = 2'b11; din = 16'hA5A5;
    tick();
    ack = 4'b0000; in_valid = 1'b0;
    checks++;
    if (vld !== 4'b1000 || w_d !== 16'hA5A5) begin
      errors++;
      $display("FAIL par_events: vld=%b w_d=%h, need 1000/A5A5", vld, w_d);
    end
    checks++;
    if (w_a !== 16'h0011 || w_b !== 16'h0022) begin
      errors++;
      $display("FAIL par_hold: w_a=%h w_b=%h, need 0011/0022", w_a, w_b);
    end
    $display("test_parallel done: vld=%b w_d=%h", vld, w_d);
  endtask

  task automatic test_illegal_select();
    slc = 2'bx1; din = 16'hDEAD;
    #1;
    if ($isunknown(slc)) begin
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL illegal_ready: in_ready=%b, need 0", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (vld !== 4'b1000 || w_a !== 16'h0011 || w_b !== 16'h0022 || w_d !== 16'hA5A5 || w_c !== 16'hBEEF) begin
        errors++;
        $display("FAIL illegal_nowrite: vld=%b w=%h/%h/%h/%h, need 1000 0011/0022/BEEF/A5A5", vld, w_a, w_b, w_c, w_d);
      end
      $display("test_illegal_select done: vld=%b", vld);
    end else begin
      $display("test_illegal_select skipped: simulator holds no unknown values");
    end
    slc = 2'b00;
  endtask

  initial begin
    test_reset();
    test_steer();
    test_backpressure();
    test_consume();
    test_parallel();
    test_illegal_select();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
